// File: rtl/jtlabrun_romrq.sv
// jtlabrun_romrq
// Responder for the main CPU ROM bus. The CPU presents a byte address with a
// chip select and waits for cpu_ok; bytes are served from a 2-entry cache of
// 32-bit lines, refilled through a single SDRAM request slot.
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   cpu_addr/cs    CPU byte address and ROM chip select
//   cpu_data/ok    returned byte and its valid flag for the current cpu_addr
//   sdram_addr     16-bit word address of the line being fetched (OFFSET added)
//   sdram_req      fetch request level, dropped once sdram_ack is seen
//   sdram_ack      arbiter accepted the request
//   data_dst/rdy   sdram_din holds this slot's line when both are high
//   sdram_din      32-bit line, byte 0 in bits [7:0]
module jtlabrun_romrq #(
  parameter int unsigned AW     = 17,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_cs,
  output logic [7:0]    cpu_data,
  output logic          cpu_ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_dst,
  input  logic          data_rdy,
  input  logic [31:0]   sdram_din
);

  localparam int unsigned TW = AW - 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t          state_q, state_d;

  logic [1:0]      valid_q;
  logic [TW-1:0]   tag_q  [2];
  logic [31:0]     line_q [2];
  logic            lru_q;

  logic [TW-1:0]   fa_q;
  logic [21:0]     saddr_q;
  logic [7:0]      data_q;
  logic            ok_q;
  logic [AW-1:0]   addr_q;

  logic [TW-1:0]   cpu_tag;
  logic            hit0, hit1, hit;
  logic            hit_idx;
  logic [31:0]     hit_line;
  logic [7:0]      hit_byte;
  logic            launch, fill;
  logic            victim;

  assign cpu_tag  = cpu_addr[AW-1:2];
  assign hit0     = cpu_cs & valid_q[0] & (tag_q[0] == cpu_tag);
  assign hit1     = cpu_cs & valid_q[1] & (tag_q[1] == cpu_tag);
  assign hit      = hit0 | hit1;
  assign hit_idx  = ~hit0;
  assign hit_line = hit0 ? line_q[0] : line_q[1];

  // Never overwrite the entry the CPU is reading in the same cycle: when a
  // fill coincides with a hit, the victim is forced to the other entry.
  assign victim   = hit ? ~hit_idx : lru_q;

  always_comb begin
    hit_byte = hit_line[7:0];
    case (cpu_addr[1:0])
      2'd0:    hit_byte = hit_line[7:0];
      2'd1:    hit_byte = hit_line[15:8];
      2'd2:    hit_byte = hit_line[23:16];
      default: hit_byte = hit_line[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sdram_req = 1'b0;
    launch    = 1'b0;
    fill      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_cs && !hit) begin
          launch  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // data_rdy arriving with the ack belongs to someone else's burst
        sdram_req = 1'b1;
        if (sdram_ack) state_d = WAIT;
      end
      WAIT: begin
        if (data_rdy && data_dst) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
      lru_q   <= 1'b0;
      fa_q    <= '0;
      saddr_q <= OFFSET;
      data_q  <= '0;
      ok_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      ok_q <= hit;
      if (hit) begin
        addr_q <= cpu_addr;
        data_q <= hit_byte;
      end
      if (launch) begin
        fa_q    <= cpu_tag;
        saddr_q <= OFFSET + 22'({cpu_tag, 1'b0});
      end
      if (fill) begin
        valid_q[victim] <= 1'b1;
        tag_q[victim]   <= fa_q;
        line_q[victim]  <= sdram_din;
        lru_q           <= ~victim;
      end else if (hit) begin
        lru_q <= ~hit_idx;
      end
    end
  end

  assign cpu_data   = data_q;
  assign sdram_addr = saddr_q;
  // addr_q comparison drops cpu_ok in the very cycle the CPU moves on
  assign cpu_ok     = ok_q & cpu_cs & (cpu_addr == addr_q);

endmodule
